// File: rtl/decoder_2_4_stream_pkg.sv
// Shared types and helpers for the streaming 2-to-4 decoder.
// Holds the default code width, the occupancy state enum and the one-hot decode function.
package decoder_2_4_stream_pkg;

  localparam int IN_W_DEF  = 2;
  localparam int OUT_W_DEF = 1 << IN_W_DEF;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_state_e;

  // A cleared enable produces an all-zero word rather than a one-hot word.
  function automatic logic [OUT_W_DEF-1:0] onehot_decode(input logic [IN_W_DEF-1:0] code,
                                                         input logic                en);
    return OUT_W_DEF'(en) << code;
  endfunction

endpackage

// File: rtl/decoder_2_4_stream_skid.sv
// Generic 2-entry valid/ready register slice (main register plus one skid register).
// s_ready comes only from registered occupancy, so there is no combinational path from m_ready.
module decoder_2_4_stream_skid
  import decoder_2_4_stream_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
);

  occ_state_e   state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         s_fire, m_fire;

  assign s_ready = (state_q != ST_TWO) && !rst;
  assign m_valid = (state_q != ST_EMPTY);
  assign m_data  = main_q;
  assign s_fire  = s_valid && s_ready;
  assign m_fire  = m_valid && m_ready;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (s_fire) begin
          main_d  = s_data;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (s_fire && m_fire) begin
          main_d = s_data;
        end else if (s_fire) begin
          skid_d  = s_data;
          state_d = ST_TWO;
        end else if (m_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (m_fire) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      // NOTE: payload registers are reset too, because the output word must read zero after reset.
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/decoder_2_4_stream.sv
// Streaming binary-to-one-hot decoder with a skid-buffered output and per-code
// saturating occurrence counters that count enabled words as they leave.
module decoder_2_4_stream
  import decoder_2_4_stream_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [IN_W-1:0]         s_code,
  input  logic                    s_en,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [(1<<IN_W)-1:0]    m_onehot,
  output logic [IN_W-1:0]         m_code,
  input  logic [IN_W-1:0]         cnt_sel,
  output logic [CNT_W-1:0]        cnt_val,
  input  logic                    cnt_clr
);

  localparam int OUT_W = 1 << IN_W;
  localparam int PAY_W = OUT_W + IN_W + 1;

  logic [OUT_W-1:0] s_onehot;
  logic [PAY_W-1:0] s_payload, m_payload;
  logic             m_en;
  logic             m_fire;

  logic [CNT_W-1:0] cnt_q [OUT_W];
  logic [CNT_W-1:0] cnt_d [OUT_W];

  assign s_onehot  = onehot_decode(s_code, s_en);
  assign s_payload = {s_en, s_code, s_onehot};

  decoder_2_4_stream_skid #(
    .W (PAY_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_payload),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_payload)
  );

  assign {m_en, m_code, m_onehot} = m_payload;
  assign m_fire  = m_valid && m_ready;
  assign cnt_val = cnt_q[cnt_sel];

  // Clear takes priority and drops any increment landing in the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      for (int i = 0; i < OUT_W; i++) cnt_d[i] = '0;
    end else if (m_fire && m_en && (cnt_q[m_code] != '1)) begin
      cnt_d[m_code] = cnt_q[m_code] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < OUT_W; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_decoder_2_4_stream.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a queue-based model of a depth-2 in-order buffer with counters.
module tb_decoder_2_4_stream;

  localparam int CNT_MAX = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid, s_ready, s_en;
  logic [1:0] s_code;
  logic       m_valid, m_ready;
  logic [3:0] m_onehot;
  logic [1:0] m_code;
  logic [1:0] cnt_sel;
  logic [7:0] cnt_val;
  logic       cnt_clr;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] code;
    logic       en;
  } word_t;

  word_t       q[$];
  int unsigned mcnt[4];

  always #5 clk = ~clk;

  decoder_2_4_stream dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_code   (s_code),
    .s_en     (s_en),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_onehot (m_onehot),
    .m_code   (m_code),
    .cnt_sel  (cnt_sel),
    .cnt_val  (cnt_val),
    .cnt_clr  (cnt_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_word(input word_t w);
    return w.en ? 4'(1 << w.code) : 4'b0000;
  endfunction

  task automatic drive(input logic v, input logic [1:0] code, input logic en,
                       input logic mr, input logic clr, input logic [1:0] sel);
    s_valid = v;  s_code  = code; s_en    = en;
    m_ready = mr; cnt_clr = clr;  cnt_sel = sel;
  endtask

  // Check outputs on the falling edge, then advance the model across the rising edge.
  task automatic cycle();
    bit    exp_sr, exp_mv, s_fire, m_fire;
    word_t w;
    @(negedge clk);
    exp_sr = !rst && (q.size() < 2);
    exp_mv = (q.size() != 0);
    chk("s_ready", 32'(s_ready), 32'(exp_sr));
    chk("m_valid", 32'(m_valid), 32'(exp_mv));
    if (exp_mv) begin
      chk("m_onehot", 32'(m_onehot), 32'(ref_word(q[0])));
      chk("m_code", 32'(m_code), 32'(q[0].code));
    end
    chk("cnt_val", 32'(cnt_val), 32'(mcnt[cnt_sel]));
    s_fire = s_valid && exp_sr;
    m_fire = exp_mv && m_ready;
    @(posedge clk);
    if (rst) begin
      q.delete();
      foreach (mcnt[i]) mcnt[i] = 0;
    end else begin
      if (m_fire) begin
        w = q.pop_front();
        if (w.en && (mcnt[w.code] < CNT_MAX)) mcnt[w.code]++;
      end
      if (cnt_clr) foreach (mcnt[i]) mcnt[i] = 0;
      if (s_fire) q.push_back('{code: s_code, en: s_en});
    end
    #1;
  endtask

  initial begin
    foreach (mcnt[i]) mcnt[i] = 0;
    rst = 1'b1;
    drive(1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0);
    cycle();
    cycle();
    rst = 1'b0;
    chk("rst_m_onehot", 32'(m_onehot), 32'h0);
    chk("rst_m_code", 32'(m_code), 32'h0);

    // Single word: code 2 enabled
    drive(1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 2'd2);
    cycle();
    drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd2);
    cycle();
    cycle();
    chk("cnt2_after_one", 32'(cnt_val), 32'd1);

    // Back-to-back 0..3 at full throughput
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 2'(c), 1'b1, 1'b1, 1'b0, 2'(c));
      cycle();
    end
    drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0);
    cycle();

    // Backpressure: fill with 1 then 3, then release
    drive(1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 2'd1);
    cycle();
    drive(1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 2'd3);
    cycle();
    drive(1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 2'd3);
    cycle();
    chk("full_s_ready", 32'(s_ready), 32'd0);
    drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd1);
    cycle();
    cycle();
    cycle();

    // Disabled word passes through uncounted
    drive(1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 2'd3);
    cycle();
    drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd3);
    cycle();
    cycle();

    // Saturation of counter 1, then clear racing a counted handshake
    for (int n = 0; n < 300; n++) begin
      drive(1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 2'd1);
      cycle();
    end
    drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd1);
    cycle();
    chk("cnt1_saturated", 32'(cnt_val), 32'd255);
    drive(1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 2'd1);
    cycle();
    drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 2'd1);
    cycle();
    drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd1);
    cycle();
    chk("cnt1_cleared", 32'(cnt_val), 32'd0);

    // Fill to two words, then reset mid-transfer
    drive(1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 2'd2);
    cycle();
    drive(1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 2'd3);
    cycle();
    rst = 1'b1;
    drive(1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 2'd2);
    cycle();
    cycle();
    rst = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd2);
    cycle();
    cycle();
    chk("post_rst_m_valid", 32'(m_valid), 32'd0);

    // Randomized traffic, backpressure and occasional clears
    for (int n = 0; n < 2000; n++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0),
            2'($urandom_range(0, 3)));
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      cycle();
      rst = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
